// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads and a per-register busy scoreboard.
// Latency: 1 cycle read; no backpressure. Optional same-edge write forwarding: REGFILE_BYPASS_EN.
// Reads never stall; re[i]=0 holds the port's last data and busy bit.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            we,
    input  logic [$clog2(DEPTH)-1:0]        wa,
    input  logic [WIDTH-1:0]                wd,
    input  logic [NRD-1:0]                  re,
    input  logic [NRD*$clog2(DEPTH)-1:0]    ra,
    output logic [NRD*WIDTH-1:0]            rd,
    output logic [NRD-1:0]                  rd_busy,
    input  logic                            busy_set,
    input  logic [$clog2(DEPTH)-1:0]        busy_addr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic w_wr_ok;
    logic w_bs_ok;

    // Out-of-range and (optionally) zero-register targets are silently dropped.
    assign w_wr_ok = we && ({1'b0, wa} < DEPTH_X) && !((ZERO_REG != 0) && (wa == '0));
    assign w_bs_ok = busy_set && ({1'b0, busy_addr} < DEPTH_X)
                     && !((ZERO_REG != 0) && (busy_addr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_ok && (wa == AW'(i))) begin
                    r_mem[i] <= wd;
                end
                // A new producer issued on the same edge as writeback keeps the register busy.
                if (w_bs_ok && (busy_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_ok && (wa == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic             w_ok;
        logic [WIDTH-1:0] w_data;
        logic             w_bsy;
        logic [WIDTH-1:0] r_data;
        logic             r_bsy;

        assign w_addr = ra[p*AW +: AW];
        assign w_ok   = ({1'b0, w_addr} < DEPTH_X) && !((ZERO_REG != 0) && (w_addr == '0));

        always_comb begin
            w_data = '0;
            w_bsy  = 1'b0;
            if (w_ok) begin
                w_data = r_mem[w_addr];
                w_bsy  = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_ok && (wa == w_addr)) begin
                    w_data = wd;
                    w_bsy  = w_bs_ok && (busy_addr == w_addr);
                end
`endif
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data <= '0;
                r_bsy  <= 1'b0;
            end else if (re[p]) begin
                r_data <= w_data;
                r_bsy  <= w_bsy;
            end
        end

        assign rd[p*WIDTH +: WIDTH] = r_data;
        assign rd_busy[p]           = r_bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized + directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wd;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic [NRD-1:0]       rd_busy;
    logic                 busy_set;
    logic [AW-1:0]        busy_addr;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra),
        .rd(rd), .rd_busy(rd_busy), .busy_set(busy_set), .busy_addr(busy_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] m_rf   [DEPTH];
    logic             m_busy [DEPTH];
    logic [WIDTH-1:0] m_rd   [NRD];
    logic             m_rb   [NRD];

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        for (int p = 0; p < NRD; p++) begin
            m_rd[p] = '0;
            m_rb[p] = 1'b0;
        end
    endtask

    // Register-transfer semantics of one clock edge, from the pre-edge state.
    task automatic model_edge();
        logic [WIDTH-1:0] nrd [NRD];
        logic             nrb [NRD];
        logic [AW-1:0]    a;
        for (int p = 0; p < NRD; p++) begin
            nrd[p] = m_rd[p];
            nrb[p] = m_rb[p];
            if (re[p]) begin
                a = ra[p*AW +: AW];
                if (a == 0) begin
                    nrd[p] = '0;
                    nrb[p] = 1'b0;
                end else begin
                    nrd[p] = m_rf[a];
                    nrb[p] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                    if (we && wa == a) begin
                        nrd[p] = wd;
                        nrb[p] = busy_set && (busy_addr == a);
                    end
`endif
                end
            end
        end
        if (we && wa != 0) begin
            m_rf[wa]   = wd;
            m_busy[wa] = 1'b0;
        end
        if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        for (int p = 0; p < NRD; p++) begin
            m_rd[p] = nrd[p];
            m_rb[p] = nrb[p];
        end
    endtask

    task automatic compare_outputs(input string tag);
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("%s.rd%0d", tag, p), rd[p*WIDTH +: WIDTH], m_rd[p]);
            chk($sformatf("%s.busy%0d", tag, p), {31'b0, rd_busy[p]}, {31'b0, m_rb[p]});
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle();
        we = 0; wa = '0; wd = '0; re = '0; ra = '0; busy_set = 0; busy_addr = '0;
    endtask

    task automatic rd_req(input logic [NRD-1:0] en, input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        re = en;
        ra = {a1, a0};
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        rd_req(2'b11, 5'd5, 5'd0);
        cyc("rd_after_reset");
        cyc("rd_after_reset2");

        idle(); we = 1; wa = 5'd7; wd = 32'hDEADBEEF;
        cyc("wr_r7");
        idle(); rd_req(2'b01, 5'd0, 5'd7);
        cyc("rd_r7");
        chk("rd_r7_const", rd[31:0], 32'hDEADBEEF);
        idle(); rd_req(2'b00, 5'd1, 5'd1);
        cyc("hold_r7");
        chk("hold_r7_const", rd[31:0], 32'hDEADBEEF);

        idle(); we = 1; wa = 5'd0; wd = 32'h1234;
        cyc("wr_r0");
        idle(); rd_req(2'b11, 5'd0, 5'd0);
        cyc("rd_r0");

        idle(); busy_set = 1; busy_addr = 5'd3;
        cyc("bs_r3");
        idle(); rd_req(2'b01, 5'd0, 5'd3);
        cyc("rd_r3_busy");
        chk("r3_busy_const", {31'b0, rd_busy[0]}, 32'd1);
        idle(); we = 1; wa = 5'd3; wd = 32'h55;
        cyc("wr_r3");
        idle(); rd_req(2'b10, 5'd3, 5'd0);
        cyc("rd_r3_clr");
        chk("r3_data_const", rd[63:32], 32'h55);
        idle(); we = 1; wa = 5'd3; wd = 32'h66; busy_set = 1; busy_addr = 5'd3;
        cyc("wr_bs_r3");
        idle(); rd_req(2'b11, 5'd3, 5'd3);
        cyc("rd_r3_setwins");

        idle(); we = 1; wa = 5'd9; wd = 32'h11;
        cyc("wr_r9_old");
        idle(); we = 1; wa = 5'd9; wd = 32'hA5A5A5A5; rd_req(2'b01, 5'd0, 5'd9);
        cyc("rdw_r9");
        idle(); rd_req(2'b01, 5'd0, 5'd9);
        cyc("rd_r9_next");

        for (int i = 0; i < 400; i++) begin
            logic sm;
            sm        = ($urandom_range(0, 1) == 1);
            we        = ($urandom_range(0, 2) != 0);
            wa        = sm ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd        = $urandom;
            busy_set  = ($urandom_range(0, 3) == 0);
            busy_addr = sm ? AW'($urandom_range(0, 7)) : AW'($urandom);
            re        = NRD'($urandom);
            ra        = {AW'($urandom_range(0, sm ? 7 : 31)), AW'($urandom_range(0, sm ? 7 : 31))};
            cyc("rand");
        end

        idle(); we = 1; wa = 5'd4; wd = 32'h77;
        cyc("wr_r4");
        idle(); rd_req(2'b11, 5'd4, 5'd4); busy_set = 1; busy_addr = 5'd4;
        cyc("rd_r4");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        idle(); rd_req(2'b11, 5'd4, 5'd4);
        cyc("rd_r4_post_rst");
        chk("r4_post_rst_const", rd[31:0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
